// File: rtl/fp_maxmin_reduce_if.sv
// Operand stream and result handshake bundle for fp_maxmin_reduce.
// Operand width is 1+EXP_W+MAN_W; index/count width is IDX_W.
interface fp_maxmin_reduce_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int IDX_W = 16
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             i_valid;
  logic             o_ready;
  logic [W-1:0]     i_data;
  logic             i_last;
  logic             i_mode;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [W-1:0]     o_res;
  logic [IDX_W-1:0] o_idx;
  logic [IDX_W-1:0] o_count;
  logic             o_nan_err;

  modport slave (
    input  i_valid, i_data, i_last, i_mode, i_res_ready,
    output o_ready, o_res_valid, o_res, o_idx, o_count, o_nan_err
  );

  modport master (
    output i_valid, i_data, i_last, i_mode, i_res_ready,
    input  o_ready, o_res_valid, o_res, o_idx, o_count, o_nan_err
  );
endinterface

// File: rtl/fp_maxmin_reduce.sv
// Streaming FP max/min reduction: running extreme, first-occurrence index,
// saturating beat count and sticky NaN flag, returned once per frame.
module fp_maxmin_reduce #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int IDX_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  fp_maxmin_reduce_if.slave  bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state;
  logic [W-1:0]     acc;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cnt;
  logic             nan;
  logic             mode;

  logic             take;
  logic             beat_nan;
  logic             beat_wins;
  logic signed [W:0] key_new;
  logic signed [W:0] key_acc;
  logic [W-1:0]     nxt_acc;
  logic [IDX_W-1:0] nxt_idx;
  logic [IDX_W-1:0] nxt_cnt;
  logic             nxt_nan;

  // Sign-magnitude mapped onto two's complement; -0 and +0 both map to 0.
  function automatic logic signed [W:0] order_key(input logic [W-1:0] v);
    logic signed [W:0] mag;
    mag = {2'b00, v[W-2:0]};
    return v[W-1] ? -mag : mag;
  endfunction

  assign take     = bus.i_valid && bus.o_ready;
  assign beat_nan = (&bus.i_data[W-2 -: EXP_W]) && (|bus.i_data[MAN_W-1:0]);

  always_comb begin
    key_new   = order_key(bus.i_data);
    key_acc   = order_key(acc);
    beat_wins = mode ? (key_new < key_acc) : (key_new > key_acc);
    nxt_acc   = acc;
    nxt_idx   = idx;
    nxt_cnt   = cnt;
    nxt_nan   = nan;
    if (state == IDLE) begin
      nxt_acc = bus.i_data;
      nxt_idx = '0;
      nxt_cnt = {{(IDX_W-1){1'b0}}, 1'b1};
      nxt_nan = beat_nan;
    end else begin
      // cnt is also the index of the incoming beat, pinned once saturated
      nxt_cnt = (cnt == '1) ? cnt : cnt + 1'b1;
      if (!nan) begin
        if (beat_nan) begin
          nxt_nan = 1'b1;
          nxt_idx = cnt;
        end else if (beat_wins) begin
          nxt_acc = bus.i_data;
          nxt_idx = cnt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      acc             <= '0;
      idx             <= '0;
      cnt             <= '0;
      nan             <= 1'b0;
      mode            <= 1'b0;
      bus.o_ready     <= 1'b0;
      bus.o_res_valid <= 1'b0;
      bus.o_res       <= '0;
      bus.o_idx       <= '0;
      bus.o_count     <= '0;
      bus.o_nan_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          bus.o_ready <= 1'b1;
          if (take) begin
            acc <= nxt_acc;
            idx <= nxt_idx;
            cnt <= nxt_cnt;
            nan <= nxt_nan;
            if (state == IDLE) mode <= bus.i_mode;
            if (bus.i_last) begin
              state           <= HOLD;
              bus.o_ready     <= 1'b0;
              bus.o_res_valid <= 1'b1;
              bus.o_res       <= nxt_nan ? QNAN : nxt_acc;
              bus.o_idx       <= nxt_idx;
              bus.o_count     <= nxt_cnt;
              bus.o_nan_err   <= nxt_nan;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (bus.i_res_ready) begin
            state           <= IDLE;
            bus.o_res_valid <= 1'b0;
            bus.o_ready     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_maxmin_reduce.sv
// Directed bench for fp_maxmin_reduce with a result scoreboard.
// Narrow IDX_W so counter saturation is reachable in a short frame.
module tb_fp_maxmin_reduce;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int IDX_W = 4;
  localparam int W     = 1 + EXP_W + MAN_W;

  typedef struct {
    logic [W-1:0]     res;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cnt;
    logic             nan;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fp_maxmin_reduce_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .IDX_W(IDX_W)) bus ();

  fp_maxmin_reduce #(.EXP_W(EXP_W), .MAN_W(MAN_W), .IDX_W(IDX_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  exp_t sb[$];
  int   vectors = 0;
  int   misses  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] res, input int idx, input int cnt, input logic nan);
    exp_t e;
    e.res = res;
    e.idx = IDX_W'(idx);
    e.cnt = IDX_W'(cnt);
    e.nan = nan;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the beat transfers.
  task automatic beat(input logic [W-1:0] d, input logic last, input logic mode);
    int n;
    n = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_last  = last;
    bus.i_mode  = mode;
    while (bus.o_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'(bus.o_ready), 64'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   n;
    chk({tag, "_latency"}, 64'(bus.o_res_valid), 64'd1);
    n = 0;
    while (bus.o_res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_res"},   64'(bus.o_res),     64'(e.res));
      chk({tag, "_idx"},   64'(bus.o_idx),     64'(e.idx));
      chk({tag, "_count"}, 64'(bus.o_count),   64'(e.cnt));
      chk({tag, "_nan"},   64'(bus.o_nan_err), 64'(e.nan));
    end
    chk({tag, "_ready_hold"}, 64'(bus.o_ready), 64'd0);
    bus.i_res_ready = 1'b1;
    @(negedge clk);
    bus.i_res_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(bus.o_res_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(bus.o_ready), 64'd1);
  endtask

  initial begin
    bus.i_valid     = 1'b0;
    bus.i_data      = '0;
    bus.i_last      = 1'b0;
    bus.i_mode      = 1'b0;
    bus.i_res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.o_ready), 64'd0);
    chk("rst_valid", 64'(bus.o_res_valid), 64'd0);
    chk("rst_res",   64'(bus.o_res), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(bus.o_ready), 64'd1);

    push_exp(32'h40400000, 2, 4, 1'b0);
    beat(32'h3F800000, 1'b0, 1'b0);
    beat(32'hC0000000, 1'b0, 1'b0);
    beat(32'h40400000, 1'b0, 1'b0);
    beat(32'h40400000, 1'b1, 1'b0);
    collect("max4");

    push_exp(32'hC0000000, 1, 4, 1'b0);
    beat(32'h3F800000, 1'b0, 1'b1);
    beat(32'hC0000000, 1'b0, 1'b1);
    beat(32'h40400000, 1'b0, 1'b1);
    beat(32'h40400000, 1'b1, 1'b1);
    collect("min4");

    push_exp(32'h00000000, 0, 2, 1'b0);
    beat(32'h00000000, 1'b0, 1'b0);
    beat(32'h80000000, 1'b1, 1'b0);
    collect("zero_max");

    push_exp(32'h80000000, 0, 2, 1'b0);
    beat(32'h80000000, 1'b0, 1'b1);
    beat(32'h00000000, 1'b1, 1'b1);
    collect("zero_min");

    push_exp(32'h7FC00000, 1, 3, 1'b1);
    beat(32'h3F800000, 1'b0, 1'b0);
    beat(32'h7F800001, 1'b0, 1'b0);
    beat(32'h7F800000, 1'b1, 1'b0);
    collect("nan");

    push_exp(32'h7F800000, 1, 4, 1'b0);
    beat(32'h00000001, 1'b0, 1'b0);
    beat(32'h7F800000, 1'b0, 1'b0);
    beat(32'h00000002, 1'b0, 1'b0);
    beat(32'hFF800000, 1'b1, 1'b0);
    collect("inf_denorm");

    push_exp(32'h80000002, 1, 3, 1'b0);
    beat(32'h80000001, 1'b0, 1'b1);
    beat(32'h80000002, 1'b0, 1'b1);
    beat(32'h00000003, 1'b1, 1'b1);
    collect("neg_denorm_min");

    // Mode flips after the first beat must be ignored (max would give 0x40000000).
    push_exp(32'h3F000000, 2, 3, 1'b0);
    beat(32'h3F800000, 1'b0, 1'b1);
    beat(32'h40000000, 1'b0, 1'b0);
    beat(32'h3F000000, 1'b1, 1'b0);
    collect("mode_latch");

    // 20 beats into a 4-bit counter; winner at beat 17 reports the saturated index.
    push_exp(32'h42000000, 15, 15, 1'b0);
    for (int i = 0; i < 20; i++)
      beat((i == 17) ? 32'h42000000 : 32'h3F800000, (i == 19), 1'b0);
    collect("saturate");

    push_exp(32'hFF800000, 0, 1, 1'b0);
    beat(32'hFF800000, 1'b1, 1'b0);
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h3F800000;
    bus.i_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(bus.o_res_valid), 64'd1);
      chk("bp_ready", 64'(bus.o_ready), 64'd0);
      chk("bp_res",   64'(bus.o_res), 64'hFF800000);
      chk("bp_count", 64'(bus.o_count), 64'd1);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    collect("bp");

    beat(32'h40400000, 1'b0, 1'b0);
    beat(32'h3F800000, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.o_ready), 64'd0);
    chk("mid_rst_valid", 64'(bus.o_res_valid), 64'd0);
    chk("mid_rst_res",   64'(bus.o_res), 64'd0);
    chk("mid_rst_idx",   64'(bus.o_idx), 64'd0);
    chk("mid_rst_count", 64'(bus.o_count), 64'd0);
    chk("mid_rst_nan",   64'(bus.o_nan_err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.o_ready), 64'd1);
    chk("post_rst_valid", 64'(bus.o_res_valid), 64'd0);
    push_exp(32'h40000000, 0, 1, 1'b0);
    beat(32'h40000000, 1'b1, 1'b0);
    collect("after_rst");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule

// File: doc/fp_maxmin_reduce.md
Name: fp_maxmin_reduce

Overview:
Streaming floating-point max/min reduction unit, parametrised in exponent and mantissa width. It consumes a frame of operands over a valid/ready handshake and compares each beat against a running extreme held in a register. At frame end it returns the extreme value, the index of its first occurrence, the element count, and a sticky NaN flag. It is the next generation of the FP32 comparator, used by pooling and top-1 logic; it adds frame accumulation, arg-index tracking and output backpressure.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, mantissa field width (operand width W = 1+EXP_W+MAN_W)
IDX_W, 16, width of the index and element counters

Ports:
clk  input  1  clock
rstn  input  1  reset
i_valid  input  1  operand beat valid
o_ready  output  1  unit accepts a beat; a beat transfers when i_valid && o_ready
i_data  input  W  operand as {sign, exp, mant}
i_last  input  1  final beat of the frame
i_mode  input  1  0 = max, 1 = min; sampled on the first beat of a frame only
o_res_valid  output  1  result valid
i_res_ready  input  1  downstream accepts the result
o_res  output  W  extreme value, or canonical qNaN
o_idx  output  IDX_W  zero-based index of the first occurrence of the extreme, or of the first NaN
o_count  output  IDX_W  number of beats in the frame, saturating
o_nan_err  output  1  at least one NaN was present in the frame

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rstn).
- Reset values: all outputs 0, including o_ready. The FSM resets to IDLE. o_ready rises on the first clk edge after rstn deasserts.
- FSM states: IDLE, ACC, HOLD.
  - IDLE: o_ready=1. An accepted beat loads the accumulator with i_data, sets idx=0 and count=1, latches the mode, and sets the NaN flag if the beat is NaN. With i_last the FSM goes to HOLD, otherwise to ACC.
  - ACC: o_ready=1. Each accepted beat increments count and is compared against the accumulator. The FSM goes to HOLD when the beat has i_last.
  - HOLD: o_ready=0 and o_res_valid=1. o_res, o_idx, o_count and o_nan_err are registered and stable. When i_res_ready=1, o_res_valid drops next cycle, the FSM returns to IDLE, and o_ready=1 that same cycle. There is exactly one bubble between frames.
- Latency: o_res_valid asserts on the cycle after the i_last beat is accepted. A single-beat frame also has 1-cycle latency.
- Ordering for non-NaN operands:
  - Sign-magnitude total order, with +/-Inf as the extremes.
  - Denormals are compared as-is, with no flush to zero.
  - -0 and +0 are equal.
- Replacement rule:
  - max mode: replace when new > acc; min mode: replace when new < acc.
  - Ties, including +/-0, keep the earlier operand and its index, so the first occurrence wins.
- NaN handling:
  - A NaN is exp all-ones with mant != 0.
  - The first NaN sets a sticky flag and captures its index. Later comparisons are ignored for the rest of the frame.
  - The result is the canonical qNaN {0, all-ones exp, 1, zeros} and o_nan_err=1.
  - Inf is not a NaN.
- Counter: count saturates at 2^IDX_W-1. Beats beyond that are still compared; a winner arriving after saturation reports index 2^IDX_W-1.
- Handshake rules:
  - i_mode changes mid-frame are ignored.
  - i_valid in HOLD is not accepted.
  - The upstream must hold i_data, i_last and i_valid until the transfer completes.
- Reset mid-frame or mid-HOLD aborts the frame with no result emitted; all state returns to reset values.

Test Plan:
- Max frame [0x3F800000, 0xC0000000, 0x40400000, 0x40400000(last)] -> o_res=0x40400000, o_idx=2, o_count=4, o_nan_err=0, o_res_valid one cycle after the last beat.
- Same frame in min mode -> o_res=0xC0000000, o_idx=1, o_count=4.
- Signed-zero ties:
  - Max frame [0x00000000, 0x80000000] -> o_res=0x00000000, o_idx=0.
  - Min frame [0x80000000, 0x00000000] -> o_res=0x80000000, o_idx=0.
- NaN frame [0x3F800000, 0x7F800001, 0x7F800000] in max mode -> o_res=0x7FC00000, o_nan_err=1, o_idx=1, o_count=3.
- Backpressure: single-beat frame 0xFF800000 with i_last, i_res_ready held low for 5 cycles, i_valid held high -> outputs stable, o_ready=0, no beat accepted. On i_res_ready=1: o_res_valid=0 next cycle and o_ready=1.
- Reset mid-frame: after 2 beats, pulse rstn low -> all outputs 0. A new frame [0x40000000(last)] returns o_res=0x40000000, o_idx=0, o_count=1.
